// File: rtl/edge_det_multi_if.sv
// Bundles the per-channel input/status vectors of edge_det_multi; the cnt member
// exists only when EDGE_DET_CNT_EN is defined.
interface edge_det_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       din;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       level;
    logic [N_CH-1:0]       rise;
    logic [N_CH-1:0]       fall;
    logic [N_CH-1:0]       pend;
    logic                  irq;
`ifdef EDGE_DET_CNT_EN
    logic [CNT_W*N_CH-1:0] cnt;
`endif

    if (N_CH < 1 || CNT_W < 1) begin : g_param_chk
        $error("edge_det_multi_if: N_CH and CNT_W must be >= 1");
    end

    modport master (
        output din, mode, clr,
        input  level, rise, fall, pend, irq
`ifdef EDGE_DET_CNT_EN
        , input cnt
`endif
    );

    modport slave (
        input  din, mode, clr,
        output level, rise, fall, pend, irq
`ifdef EDGE_DET_CNT_EN
        , output cnt
`endif
    );
endinterface

// File: rtl/edge_det_multi.sv
// Multi-channel synchronise + glitch filter + edge detector with sticky pending flags and irq.
// Input-to-pulse latency SYNC_STAGES+FILT_CYCLES-1 cycles; no backpressure. Macro EDGE_DET_CNT_EN adds event counters.
module edge_det_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    edge_det_multi_if.slave  bus
);
    localparam int              FC_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);

    if (N_CH < 1 || SYNC_STAGES < 2 || FILT_CYCLES < 1 || CNT_W < 1) begin : g_param_chk
        $error("edge_det_multi: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  s;
    logic [N_CH-1:0][FC_W-1:0]        fc_q, fc_d;
    logic [N_CH-1:0]                  level_q, level_d;
    logic [N_CH-1:0]                  rise_q, rise_d;
    logic [N_CH-1:0]                  fall_q, fall_d;
    logic [N_CH-1:0]                  pend_q, pend_d;
    logic [N_CH-1:0]                  sel;
    logic                             irq_q, irq_d;

    assign s = sync_q[SYNC_STAGES-1];

    // fc counts consecutive cycles that s has disagreed with the accepted level
    always_comb begin
        fc_d    = fc_q;
        level_d = level_q;
        for (int i = 0; i < N_CH; i++) begin
            if (s[i] == level_q[i]) begin
                fc_d[i] = '0;
            end else if (fc_q[i] == FC_LAST) begin
                level_d[i] = s[i];
                fc_d[i]    = '0;
            end else begin
                fc_d[i] = fc_q[i] + FC_W'(1);
            end
        end
    end

    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
        sel    = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel[i] = (bus.mode[2*i] & rise_d[i]) | (bus.mode[2*i+1] & fall_d[i]);
        end
        // a new event beats a simultaneous clear so nothing is lost
        pend_d = sel | (pend_q & ~bus.clr);
        irq_d  = |pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            fc_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.din};
            fc_q    <= fc_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.pend  = pend_q;
    assign bus.irq   = irq_q;

`ifdef EDGE_DET_CNT_EN
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // saturating; a clear coinciding with an event restarts the count at one
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (sel[i] && bus.clr[i]) begin
                cnt_d[i] = CNT_W'(1);
            end else if (bus.clr[i]) begin
                cnt_d[i] = '0;
            end else if (sel[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt = cnt_q;
`endif
endmodule

// File: tb/tb_edge_det_multi.sv
// Randomised and directed stimulus for edge_det_multi, compared every cycle against a
// sample-history reference model; build with EDGE_DET_CNT_EN to also exercise the counters.
module tb_edge_det_multi;
    localparam int N_CH = 4;
    localparam int SYNC = 2;
    localparam int FILT = 4;
`ifdef EDGE_DET_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif
    localparam int HL = SYNC + FILT;

    logic clk = 1'b0;
    logic rst;

    edge_det_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    edge_det_multi #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: hist[c][j] is the raw din sample taken j edges ago. The
    // accepted level flips once the FILT samples seen through the SYNC-deep
    // synchroniser all disagree with it.
    logic [HL-1:0]    hist [N_CH];
    logic [N_CH-1:0]  m_level, m_rise, m_fall, m_pend;
    logic             m_irq;
    logic [CNT_W-1:0] m_cnt [N_CH];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                hist[c]  = '0;
                m_cnt[c] = '0;
            end
            m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                bit flip, old, sel;
                hist[c] = {hist[c][HL-2:0], bus.din[c]};
                flip = 1'b1;
                for (int j = SYNC; j < HL; j++)
                    if (hist[c][j] == m_level[c]) flip = 1'b0;
                old        = m_level[c];
                m_level[c] = flip ? ~old : old;
                m_rise[c]  = flip & ~old;
                m_fall[c]  = flip & old;
                sel = (bus.mode[2*c] & m_rise[c]) | (bus.mode[2*c+1] & m_fall[c]);
                if (sel) m_pend[c] = 1'b1;
                else if (bus.clr[c]) m_pend[c] = 1'b0;
                if (sel && bus.clr[c]) m_cnt[c] = 1;
                else if (bus.clr[c]) m_cnt[c] = 0;
                else if (sel && m_cnt[c] != {CNT_W{1'b1}}) m_cnt[c] = m_cnt[c] + 1'b1;
            end
        end
        m_irq = |m_pend;
    endtask

    task automatic compare_all();
        chk("level", 64'(bus.level), 64'(m_level));
        chk("rise",  64'(bus.rise),  64'(m_rise));
        chk("fall",  64'(bus.fall),  64'(m_fall));
        chk("pend",  64'(bus.pend),  64'(m_pend));
        chk("irq",   64'(bus.irq),   64'(m_irq));
`ifdef EDGE_DET_CNT_EN
        for (int c = 0; c < N_CH; c++)
            chk("cnt", 64'(bus.cnt[c*CNT_W +: CNT_W]), 64'(m_cnt[c]));
`endif
    endtask

    // Inputs are driven on the negedge; one call advances one posedge and checks.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int hold [N_CH];
    int lat;
    logic r3_at_lat;
    logic [CNT_W-1:0] cnt_exp [5];

    initial begin
        rst = 1'b1;
        bus.din  = 4'b1010;
        bus.mode = '0;
        bus.clr  = '0;

        // reset, then latency of the rise caused by din held high through reset
        run(3);
        chk("rst_level", 64'(bus.level), 64'(0));
        chk("rst_pend",  64'(bus.pend),  64'(0));
        chk("rst_irq",   64'(bus.irq),   64'(0));
        rst = 1'b0;
        lat = -1;
        r3_at_lat = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (lat < 0 && bus.rise[1]) begin
                lat = i;
                r3_at_lat = bus.rise[3];
            end
        end
        chk("rst_rise_latency", 64'(lat), 64'(5));
        chk("rst_rise3_same_cycle", 64'(r3_at_lat), 64'(1));
        chk("rst_pend_mode0", 64'(bus.pend), 64'(0));

        // glitch of FILT-1 cycles on ch0
        bus.mode = 8'b0000_0001;
        bus.din[0] = 1'b1;
        run(3);
        bus.din[0] = 1'b0;
        run(10);
        chk("glitch_level0", 64'(bus.level[0]), 64'(0));
        chk("glitch_pend0",  64'(bus.pend[0]),  64'(0));

        // clean rise and fall on ch2, both edges selected
        bus.mode = 8'b0011_0001;
        bus.din[2] = 1'b1;
        run(10);
        chk("clean_pend2", 64'(bus.pend[2]), 64'(1));
        chk("clean_irq",   64'(bus.irq),     64'(1));
        bus.din[2] = 1'b0;
        run(10);

        // clear racing a new selected rise on ch0
        bus.clr = 4'b1110;
        cycle();
        bus.clr = '0;
        bus.din[0] = 1'b1;
        run(10);
        chk("set_pend0", 64'(bus.pend[0]), 64'(1));
        bus.din[0] = 1'b0;
        run(10);
        bus.din[0] = 1'b1;
        run(5);
        bus.clr[0] = 1'b1;
        cycle();
        chk("clr_vs_set_rise0", 64'(bus.rise[0]), 64'(1));
        chk("clr_vs_set_pend0", 64'(bus.pend[0]), 64'(1));
        cycle();
        bus.clr[0] = 1'b0;
        chk("clr_alone_pend0", 64'(bus.pend[0]), 64'(0));
        chk("clr_alone_irq",   64'(bus.irq),     64'(0));

        // fall-only mode on ch1
        bus.din[1] = 1'b0;
        run(10);
        bus.mode[3:2] = 2'b10;
        bus.din[1] = 1'b1;
        run(10);
        chk("fallmode_pend1_after_rise", 64'(bus.pend[1]), 64'(0));
        bus.din[1] = 1'b0;
        run(10);
        chk("fallmode_pend1_after_fall", 64'(bus.pend[1]), 64'(1));

`ifdef EDGE_DET_CNT_EN
        // saturating counter on ch3
        cnt_exp[0] = 1; cnt_exp[1] = 2; cnt_exp[2] = 3; cnt_exp[3] = 3; cnt_exp[4] = 3;
        bus.mode[7:6] = 2'b11;
        bus.clr[3] = 1'b1;
        cycle();
        bus.clr[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.din[3] = ~bus.din[3];
            run(8);
            chk("cnt3_sat", 64'(bus.cnt[3*CNT_W +: CNT_W]), 64'(cnt_exp[k]));
        end
        bus.clr[3] = 1'b1;
        cycle();
        bus.clr[3] = 1'b0;
        chk("cnt3_clr", 64'(bus.cnt[3*CNT_W +: CNT_W]), 64'(0));
`endif

        // random phase: per-channel hold times straddle the filter length
        for (int c = 0; c < N_CH; c++) hold[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold[c] == 0) begin
                    bus.din[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 8);
                end
                hold[c]--;
            end
            bus.clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 63) == 0) bus.mode = 8'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/edge_det_multi.md
Name: edge_det_multi

Overview:
Parametrised multi-channel successor of the single-input edge detector. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable stable time, and emits single-cycle rise/fall pulses. Per-channel mode selects which edges set a sticky pending flag, and the pending flags are OR-ed into one interrupt. Sits between board-level inputs (buttons, UART lines, status pins) and control FSMs or an interrupt register.

Parameters:
N_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
FILT_CYCLES, 4, consecutive cycles synchronised input must differ from filtered level before it is accepted (>=1)
CNT_W, 8, width of optional per-channel event counter

Ports:
clk  input  1  clock, posedge active
rst  input  1  synchronous reset, active high
din  input  N_CH  raw asynchronous inputs
mode  input  2*N_CH  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  input  N_CH  per-channel clear of pend (and of cnt if enabled)
level  output  N_CH  filtered, synchronised level
rise  output  N_CH  one-cycle pulse on filtered 0->1
fall  output  N_CH  one-cycle pulse on filtered 1->0
pend  output  N_CH  sticky flag set by mode-selected edge
irq  output  1  |pend
cnt  output  CNT_W*N_CH  event counters, present only with EDGE_DET_CNT_EN

Behaviour:
- Single clock domain. rst is synchronous and active high: on a clk posedge with rst=1, all sync FFs, filter counters, level, rise, fall, pend, irq and cnt go to 0. rst overrides every other input.
- Synchroniser: SYNC_STAGES-deep shift chain per channel. Its last stage is s.
- Filter, per channel, using counter fc of width clog2(FILT_CYCLES+1):
  - s == level -> fc <= 0.
  - s != level and fc < FILT_CYCLES-1 -> fc <= fc+1.
  - s != level and fc == FILT_CYCLES-1 -> level <= s, fc <= 0.
  - FILT_CYCLES=1: level follows s with one register delay.
  - A pulse on s shorter than FILT_CYCLES cycles never changes level and produces no edge.
- Edge outputs are registered and update on the same clock edge as level:
  - rise <= (level becomes 1).
  - fall <= (level becomes 0).
  - Each pulse lasts exactly one cycle. rise and fall are never both high on one channel.
- Latency: if din changes and stays stable before posedge t0, level and the pulse are visible after posedge t0+SYNC_STAGES+FILT_CYCLES-1. With defaults, 5 cycles.
- Selected edge sel = (mode[0] & rise_next) | (mode[1] & fall_next), evaluated on the same edge as rise/fall.
- pend update:
  - sel -> pend <= 1.
  - else clr -> pend <= 0.
  - Simultaneous sel and clr: set wins, so no event is lost.
  - mode=00 never sets pend. Changing mode does not alter an existing pend.
- irq is registered from the next value of pend, so irq and pend assert together.
- Channels are fully independent. There is no cross-channel priority.
- Reset with din held high: level starts at 0, so a rise pulse appears after the latency above. This is intended.
- Reset mid-filter: the count is discarded and no pulse is emitted.

Optional Feature:
Macro EDGE_DET_CNT_EN.
- Defined:
  - Port cnt exists. Each channel's CNT_W-bit counter increments on each sel event and saturates at 2^CNT_W-1 (no wrap).
  - clr zeroes the counter. Simultaneous sel and clr -> counter <= 1.
  - Reset value is 0.
- Undefined: port cnt and all counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 3 cycles with din=4'b1010 -> level, rise, fall, pend, irq all 0. After release, rise[1] and rise[3] pulse exactly 5 cycles later. pend stays 0 because mode=0.
- Glitch reject: mode=01 on ch0, din[0] high for 3 cycles then low (FILT_CYCLES=4) -> no level change, no rise, pend[0]=0.
- Clean edge: mode=11 on ch2, din[2] 0->1, held 10 cycles, then 1->0 -> rise[2] one cycle at +5, fall[2] one cycle 5 cycles after the falling change. pend[2]=1, irq=1 from the first pulse.
- Clear vs set: pend[0]=1, assert clr[0] on the same cycle as a new selected rise -> pend[0] stays 1. clr[0] alone the next cycle -> pend[0]=0, irq=0 if no other pend.
- Mode filtering: mode=10 on ch1, rising edge -> rise[1] pulses, pend[1]=0. Falling edge -> pend[1]=1.
- EDGE_DET_CNT_EN, CNT_W=2: 5 selected edges on ch3 -> cnt[3] reads 1, 2, 3, 3, 3. clr[3] -> 0.
